// File: rtl/counter_sequencer.sv
// Modulo counter plus a command-driven sequencer that runs it for a programmed
// number of wrap (carry) events in a chosen direction.

module counter #(
    parameter int P_BASE = 32,
    parameter int P_BIT  = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             up_dw,
    output logic [P_BIT-1:0] count,
    output logic             carry
);

    localparam logic [P_BIT-1:0] TOP = P_BIT'(P_BASE - 1);
    localparam logic [P_BIT-1:0] ONE = P_BIT'(1);

    logic [P_BIT-1:0] count_q;
    logic [P_BIT-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (enable) begin
            if (up_dw) begin
                count_d = (count_q == TOP) ? '0 : count_q + ONE;
            end else begin
                count_d = (count_q == '0) ? TOP : count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Carry marks the step that wraps, so it only exists while stepping.
    assign carry = enable & (up_dw ? (count_q == TOP) : (count_q == '0));
    assign count = count_q;

endmodule

module counter_sequencer #(
    parameter int P_BASE    = 32,
    parameter int P_BIT     = 32,
    parameter int P_REP_BIT = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [P_REP_BIT-1:0] cmd_rep,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [P_REP_BIT-1:0] rep_left,
    output logic [P_BIT-1:0]     count,
    output logic                 tick
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [P_REP_BIT-1:0] REP_ONE = P_REP_BIT'(1);

    state_t               state_q;
    state_t               state_d;
    logic                 dir_q;
    logic                 dir_d;
    logic [P_REP_BIT-1:0] rep_left_q;
    logic [P_REP_BIT-1:0] rep_left_d;
    logic                 aborted_q;
    logic                 aborted_d;

    logic accept;
    logic cnt_enable;
    logic cnt_carry;

    assign cmd_ready  = (state_q == ST_IDLE) & ~abort;
    assign accept     = cmd_valid & cmd_ready;
    assign cnt_enable = (state_q == ST_RUN) & ~abort;

    counter #(
        .P_BASE (P_BASE),
        .P_BIT  (P_BIT)
    ) u_counter (
        .clk    (clk),
        .resetn (resetn),
        .enable (cnt_enable),
        .up_dw  (dir_q),
        .count  (count),
        .carry  (cnt_carry)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        rep_left_d = rep_left_q;
        aborted_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d      = cmd_dir;
                    rep_left_d = cmd_rep;
                    state_d    = (cmd_rep == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a final carry; the gated enable already hides it.
                if (abort) begin
                    state_d    = ST_IDLE;
                    rep_left_d = '0;
                    aborted_d  = 1'b1;
                end else if (cnt_carry && rep_left_q != '0) begin
                    rep_left_d = rep_left_q - REP_ONE;
                    if (rep_left_q == REP_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b1;
            rep_left_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            rep_left_q <= rep_left_d;
            aborted_q  <= aborted_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign aborted  = aborted_q;
    assign rep_left = rep_left_q;
    assign tick     = cnt_carry;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: constant vector table, hand-written corner
// sequences and random commands, all cross-checked by a cycle-level model.

module tb_counter_sequencer;

    localparam int B = 4;
    localparam int W = 4;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_dir = 1'b0;
    logic [R-1:0] cmd_rep = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [R-1:0] rep_left;
    logic [W-1:0] count;
    logic         tick;

    int check_count = 0;
    int pass_count  = 0;

    // Behavioural model: plain integers and flags updated once per clock.
    int m_count = 0;
    int m_rep   = 0;
    bit m_dir   = 1'b1;
    bit m_busy  = 1'b0;
    bit m_run   = 1'b0;
    bit m_done  = 1'b0;
    bit m_abtd  = 1'b0;

    typedef struct {
        bit     v;
        bit     d;
        int     r;
        bit     a;
        bit     e_busy;
        bit     e_ready;
        bit     e_done;
        bit     e_tick;
        int     e_count;
        int     e_rep;
    } vec_t;

    vec_t vecs[11];

    counter_sequencer #(
        .P_BASE    (B),
        .P_BIT     (W),
        .P_REP_BIT (R)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_rep   (cmd_rep),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .rep_left  (rep_left),
        .count     (count),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_tick(input bit a);
        return m_run && !a && (m_dir ? (m_count == B - 1) : (m_count == 0));
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_rep   = 0;
        m_dir   = 1'b1;
        m_busy  = 1'b0;
        m_run   = 1'b0;
        m_done  = 1'b0;
        m_abtd  = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit d, input int r, input bit a);
        bit t;
        t      = model_tick(a);
        m_abtd = 1'b0;
        if (!m_busy) begin
            if (v && !a) begin
                m_dir  = d;
                m_rep  = r;
                m_busy = 1'b1;
                if (r == 0) m_done = 1'b1;
                else        m_run  = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (a) begin
            m_run  = 1'b0;
            m_busy = 1'b0;
            m_rep  = 0;
            m_abtd = 1'b1;
        end else begin
            m_count = m_dir ? (m_count + 1) % B : (m_count + B - 1) % B;
            if (t) begin
                m_rep = m_rep - 1;
                if (m_rep == 0) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input bit a);
        checkOutput("busy",     int'(busy),     int'(m_busy));
        checkOutput("ready",    int'(cmd_ready), int'(!m_busy && !a));
        checkOutput("done",     int'(done),     int'(m_done));
        checkOutput("aborted",  int'(aborted),  int'(m_abtd));
        checkOutput("tick",     int'(tick),     int'(model_tick(a)));
        checkOutput("count",    int'(count),    m_count);
        checkOutput("rep_left", int'(rep_left), m_rep);
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, then advance.
    task automatic applyStimulus(input bit v, input bit d, input int r, input bit a);
        cmd_valid = v;
        cmd_dir   = d;
        cmd_rep   = R'(r);
        abort     = a;
        #2;
        check_model(a);
        @(posedge clk);
        model_step(v, d, r, a);
        #1;
    endtask

    initial begin
        int seq[8];
        seq = '{2, 1, 0, 3, 2, 1, 0, 3};

        // Up run rep=2 from count 0, expected values written out per cycle.
        vecs[0] = '{1, 1, 2, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 1; i <= 8; i++) begin
            vecs[i] = '{0, 1, 2, 0, 1, 0, 0, (i % 4 == 0), (i - 1) % 4, (i <= 4) ? 2 : 1};
        end
        vecs[9]  = '{0, 1, 2, 0, 1, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 1, 2, 0, 0, 1, 0, 0, 0, 0};

        #3;
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_aborted", int'(aborted), 0);
        checkOutput("reset_rep_left", int'(rep_left), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            cmd_valid = vecs[i].v;
            cmd_dir   = vecs[i].d;
            cmd_rep   = R'(vecs[i].r);
            abort     = vecs[i].a;
            #2;
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            checkOutput($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(vecs[i].e_ready));
            checkOutput($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
            checkOutput($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].e_tick));
            checkOutput($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
            checkOutput($sformatf("vec%0d_rep", i), int'(rep_left), vecs[i].e_rep);
            check_model(vecs[i].a);
            @(posedge clk);
            model_step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].a);
            #1;
        end

        // Down run from count 0 wraps immediately.
        applyStimulus(1, 0, 1, 0);
        checkOutput("down1_tick", int'(tick), 1);
        checkOutput("down1_count", int'(count), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("down1_done", int'(done), 1);
        checkOutput("down1_end_count", int'(count), 3);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 2, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("down2_seq%0d", i), int'(count), seq[i]);
        end
        checkOutput("down2_done", int'(done), 1);

        // Zero repeat: straight to DONE, one busy cycle, count untouched.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("zero_busy", int'(busy), 1);
        checkOutput("zero_done", int'(done), 1);
        checkOutput("zero_count", int'(count), 3);
        applyStimulus(0, 0, 0, 0);
        checkOutput("zero_idle", int'(busy), 0);

        // Bring count to 0 with an up rep=1, then abort on the 6th RUN cycle.
        applyStimulus(1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_abort_count", int'(count), 0);
        applyStimulus(1, 1, 3, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("abort_cycle_count", int'(count), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort_count", int'(count), 1);
        checkOutput("abort_pulse", int'(aborted), 1);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_rep", int'(rep_left), 0);
        checkOutput("abort_busy", int'(busy), 0);

        // Abort held in IDLE blocks a valid command.
        applyStimulus(1, 1, 2, 1);
        checkOutput("idle_abort_not_accepted", int'(busy), 0);
        checkOutput("idle_abort_pulse_gone", int'(aborted), 0);

        // Valid held high through a whole run, including DONE.
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 1, 0);
        checkOutput("held_valid_busy", int'(busy), 1);

        // Asynchronous reset mid-run.
        cmd_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_aborted", int'(aborted), 0);
        checkOutput("rst_rep", int'(rep_left), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random commands against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that owns one `counter` instance and runs it for a programmed number of wrap events in a chosen direction.
- Accepts one command at a time over a valid/ready handshake. Drives the counter's `enable` and `up_dw`, counts its `carry` pulses, and reports completion with a one-cycle `done` pulse.
- Used by timing/scheduling logic that needs "wait N full periods of P_BASE cycles" without owning the counter directly.

Parameters:
- P_BASE, 32, counter modulus; passed to the counter. Must be >= 2.
- P_BIT, 32, counter width; passed to the counter. Must satisfy P_BASE <= 2^P_BIT.
- P_REP_BIT, 8, width of the repeat field and of `rep_left`.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  controller can accept a command this cycle
- cmd_dir  input  1  direction; 1 = up, 0 = down; sampled on accept
- cmd_rep  input  P_REP_BIT  number of carry events to run; sampled on accept
- abort  input  1  terminate the current run
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse: run completed normally
- aborted  output  1  one-cycle pulse: run terminated by abort
- rep_left  output  P_REP_BIT  carry events still outstanding
- count  output  P_BIT  live counter value
- tick  output  1  counter carry, passed through

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, rep_left=0, dir register=1.
  - done=0, aborted=0, count=0.
  - Counter enable is low throughout reset.
- States: IDLE, RUN, DONE.
- cmd_ready = (state==IDLE) & !abort. Accept = cmd_valid & cmd_ready.
- busy = (state!=IDLE).
- Counter drive:
  - enable = (state==RUN) & !abort.
  - up_dw = registered dir.
  - tick = counter carry, which is already gated by enable.
- IDLE:
  - On accept, latch cmd_dir and cmd_rep into rep_left.
  - If cmd_rep==0, go to DONE; the counter is never enabled.
  - Otherwise go to RUN.
  - Without an accept, stay in IDLE. Abort in IDLE has no effect except blocking accept.
- RUN:
  - Counter steps every cycle.
  - On each cycle with tick=1, rep_left decrements by 1.
  - When tick=1 and rep_left==1, go to DONE. That is the same edge on which the counter wraps, and rep_left becomes 0.
- RUN with abort=1:
  - Go to IDLE next edge. The counter does not step in the abort cycle, so count freezes.
  - aborted pulses for 1 cycle, done stays 0, rep_left is cleared to 0.
  - Abort takes priority over a simultaneous final tick: tick is 0 because enable is gated.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE unconditionally. Abort has no effect.
  - cmd_ready is 0 in DONE, so back-to-back commands have a 1-cycle gap.
- The counter is never cleared between commands.
  - An up run ends with count=0.
  - A down run ends with count=P_BASE-1.
  - An aborted run leaves count at its frozen value.
  - The first wrap of the next run depends on the current count.
- Latency: starting from count 0 in the up direction, a run with rep=R spends exactly R*P_BASE cycles in RUN; done asserts the cycle after the last tick.
- rep_left is unsigned. It never decrements below 0 and never wraps.
- Reset mid-run returns everything to reset values immediately. No done or aborted pulse is generated.

Test Plan:
- Up run:
  - Stimulus: P_BASE=4, reset, then accept {dir=1, rep=2}.
  - Expected: RUN lasts 8 cycles; tick on RUN cycles 4 and 8; rep_left steps 2→1→0; done pulses once on cycle 9; final count=0; cmd_ready returns on cycle 10.
- Down wrap from 0:
  - Stimulus: from count=0, accept {dir=0, rep=1}.
  - Expected: tick on the first RUN cycle; count=3; done on the next cycle.
  - Follow-up: {dir=0, rep=2} gives an 8-cycle RUN, sequence 2,1,0,3,2,1,0,3; ends count=3.
- Zero repeat:
  - Stimulus: accept {dir=1, rep=0}.
  - Expected: DONE on the next cycle with no tick and count unchanged; busy high for exactly 1 cycle.
- Abort:
  - Stimulus: {dir=1, rep=3}, abort on the 6th RUN cycle (count=1).
  - Expected: count frozen at 1; aborted pulses once; done never asserts; rep_left=0; state returns to IDLE.
  - Abort held high in IDLE together with cmd_valid: cmd_ready=0 and the command is not accepted.
- Handshake and reset:
  - Stimulus: cmd_valid held high while busy.
  - Expected: cmd_ready=0 and the command is not accepted until IDLE.
  - Stimulus: assert resetn=0 mid-RUN.
  - Expected: immediately count=0, busy=0, no done or aborted pulse.
